// File: rtl/pistorm_pkg.sv
// Shared encodings for the Pi-side access sequencer: transfer sizes, completion status, FSM states.
package pistorm_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_WORD = 2'd1,
    SZ_LONG = 2'd2,
    SZ_RSVD = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    ST_OK      = 2'd0,
    ST_BERR    = 2'd1,
    ST_ADDR    = 2'd2,
    ST_TIMEOUT = 2'd3
  } status_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CYC1  = 3'd1,
    WAIT1 = 3'd2,
    CYC2  = 3'd3,
    WAIT2 = 3'd4,
    DONE  = 3'd5
  } state_e;

  // Words and longs must be even-aligned on a 16-bit bus; size 3 is never legal.
  function automatic logic addr_fault(input size_e size, input logic a0);
    return (size == SZ_RSVD) || ((size != SZ_BYTE) && a0);
  endfunction

endpackage

// File: rtl/pi_access_sequencer_if.sv
// Pi request/response and 16-bit bus-cycle signals; master is the sequencer, slave is the Pi host plus bus engine.
interface pi_access_sequencer_if;
  logic        req_valid;
  logic        req_ready;
  logic [23:0] req_addr;
  logic [1:0]  req_size;
  logic        req_read;
  logic [2:0]  req_fc;
  logic [31:0] req_wdata;

  logic        rsp_done;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_status;

  logic        cyc_valid;
  logic        cyc_ready;
  logic [22:0] cyc_addr;
  logic        cyc_uds;
  logic        cyc_lds;
  logic        cyc_read;
  logic [2:0]  cyc_fc;
  logic [15:0] cyc_wdata;
  logic        cyc_done;
  logic        cyc_berr;
  logic [15:0] cyc_rdata;
  logic        cyc_abort;

  modport master (
    input  req_valid, req_addr, req_size, req_read, req_fc, req_wdata,
    output req_ready, rsp_done, rsp_rdata, rsp_status,
    output cyc_valid, cyc_addr, cyc_uds, cyc_lds, cyc_read, cyc_fc, cyc_wdata, cyc_abort,
    input  cyc_ready, cyc_done, cyc_berr, cyc_rdata
  );

  modport slave (
    output req_valid, req_addr, req_size, req_read, req_fc, req_wdata,
    input  req_ready, rsp_done, rsp_rdata, rsp_status,
    input  cyc_valid, cyc_addr, cyc_uds, cyc_lds, cyc_read, cyc_fc, cyc_wdata, cyc_abort,
    output cyc_ready, cyc_done, cyc_berr, cyc_rdata
  );
endinterface

// File: rtl/pi_lane_map.sv
// Combinational lane steering: strobes and write lanes for the cycle being issued,
// and placement of returned bus data into the 32-bit right-justified result.
module pi_lane_map
  import pistorm_pkg::*;
(
  input  size_e       size,
  input  logic        addr0,
  input  logic        wr_phase,
  input  logic        rd_phase,
  input  logic [31:0] wdata,
  input  logic [15:0] rdata,
  input  logic [31:0] rdata_prev,
  output logic        uds,
  output logic        lds,
  output logic [15:0] lane_wdata,
  output logic [31:0] rdata_next
);

  always_comb begin
    uds        = 1'b0;
    lds        = 1'b0;
    lane_wdata = '0;
    rdata_next = rdata_prev;
    case (size)
      SZ_BYTE: begin
        // Even byte rides the upper lane; writes drive both lanes so either works.
        uds        = ~addr0;
        lds        = addr0;
        lane_wdata = {2{wdata[7:0]}};
        rdata_next = {24'd0, (addr0 ? rdata[7:0] : rdata[15:8])};
      end
      SZ_WORD: begin
        uds        = 1'b1;
        lds        = 1'b1;
        lane_wdata = wdata[15:0];
        rdata_next = {16'd0, rdata};
      end
      SZ_LONG: begin
        uds        = 1'b1;
        lds        = 1'b1;
        lane_wdata = wr_phase ? wdata[15:0] : wdata[31:16];
        rdata_next = rd_phase ? {rdata_prev[31:16], rdata} : {rdata, rdata_prev[15:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/pi_access_sequencer.sv
// Splits Pi byte/word/long accesses into one or two 16-bit bus cycles with alignment,
// bus-error and timeout handling; all outputs registered.
module pi_access_sequencer
  import pistorm_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                   sys_clk,
  input  logic                   reset,
  pi_access_sequencer_if.master  bus
);

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_e      state;
  size_e       size_q;
  logic        read_q;
  logic [23:0] addr_q;
  logic [31:0] wdata_q;
  logic [15:0] wait_cnt;

  size_e       lm_size;
  logic        lm_a0;
  logic [31:0] lm_wdata;
  logic        lm_uds;
  logic        lm_lds;
  logic [15:0] lm_lane_wdata;
  logic [31:0] lm_rdata_next;

  // In IDLE the map looks at the live request so the first cycle can issue on the accept edge.
  assign lm_size  = (state == IDLE) ? size_e'(bus.req_size) : size_q;
  assign lm_a0    = (state == IDLE) ? bus.req_addr[0]      : addr_q[0];
  assign lm_wdata = (state == IDLE) ? bus.req_wdata        : wdata_q;

  pi_lane_map u_lane_map (
    .size       (lm_size),
    .addr0      (lm_a0),
    .wr_phase   (state != IDLE),
    .rd_phase   (state == WAIT2),
    .wdata      (lm_wdata),
    .rdata      (bus.cyc_rdata),
    .rdata_prev (bus.rsp_rdata),
    .uds        (lm_uds),
    .lds        (lm_lds),
    .lane_wdata (lm_lane_wdata),
    .rdata_next (lm_rdata_next)
  );

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      size_q         <= SZ_BYTE;
      read_q         <= 1'b0;
      addr_q         <= '0;
      wdata_q        <= '0;
      wait_cnt       <= '0;
      bus.req_ready  <= 1'b1;
      bus.rsp_done   <= 1'b0;
      bus.rsp_rdata  <= '0;
      bus.rsp_status <= ST_OK;
      bus.cyc_valid  <= 1'b0;
      bus.cyc_addr   <= '0;
      bus.cyc_uds    <= 1'b0;
      bus.cyc_lds    <= 1'b0;
      bus.cyc_read   <= 1'b0;
      bus.cyc_fc     <= '0;
      bus.cyc_wdata  <= '0;
      bus.cyc_abort  <= 1'b0;
    end else begin
      bus.rsp_done  <= 1'b0;
      bus.cyc_abort <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            size_q        <= size_e'(bus.req_size);
            read_q        <= bus.req_read;
            addr_q        <= bus.req_addr;
            wdata_q       <= bus.req_wdata;
            bus.req_ready <= 1'b0;
            bus.rsp_rdata <= '0;
            if (addr_fault(size_e'(bus.req_size), bus.req_addr[0])) begin
              bus.rsp_status <= ST_ADDR;
              bus.rsp_done   <= 1'b1;
              state          <= DONE;
            end else begin
              bus.rsp_status <= ST_OK;
              bus.cyc_valid  <= 1'b1;
              bus.cyc_addr   <= bus.req_addr[23:1];
              bus.cyc_uds    <= lm_uds;
              bus.cyc_lds    <= lm_lds;
              bus.cyc_read   <= bus.req_read;
              bus.cyc_fc     <= bus.req_fc;
              bus.cyc_wdata  <= lm_lane_wdata;
              state          <= CYC1;
            end
          end
        end
        CYC1, CYC2: begin
          if (bus.cyc_ready) begin
            bus.cyc_valid <= 1'b0;
            wait_cnt      <= '0;
            state         <= (state == CYC1) ? WAIT1 : WAIT2;
          end
        end
        WAIT1, WAIT2: begin
          // A termination arriving on the timeout cycle still counts as a normal finish.
          if (bus.cyc_done) begin
            if (read_q && !bus.cyc_berr) bus.rsp_rdata <= lm_rdata_next;
            if (bus.cyc_berr) begin
              bus.rsp_status <= ST_BERR;
              bus.rsp_done   <= 1'b1;
              state          <= DONE;
            end else if (state == WAIT1 && size_q == SZ_LONG) begin
              // Long-aligned address means addr+2 is a plain word increment, wrapping at 24 bits.
              bus.cyc_valid <= 1'b1;
              bus.cyc_addr  <= addr_q[23:1] + 23'd1;
              bus.cyc_wdata <= lm_lane_wdata;
              state         <= CYC2;
            end else begin
              bus.rsp_done <= 1'b1;
              state        <= DONE;
            end
          end else if (wait_cnt == TO_LAST) begin
            bus.cyc_abort  <= 1'b1;
            bus.rsp_status <= ST_TIMEOUT;
            bus.rsp_done   <= 1'b1;
            state          <= DONE;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        DONE: begin
          bus.req_ready <= 1'b1;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pi_access_sequencer.sv
// Table-driven bench with expected-cycle and expected-response scoreboards plus hand-written timeout/reset sequences.
module tb_pi_access_sequencer;

  logic sys_clk = 1'b0;
  logic reset   = 1'b1;
  always #5 sys_clk = ~sys_clk;

  pi_access_sequencer_if bus ();

  pi_access_sequencer #(.TIMEOUT_CYCLES(8)) dut (
    .sys_clk (sys_clk),
    .reset   (reset),
    .bus     (bus.master)
  );

  typedef struct packed {
    logic [22:0] addr;
    logic        uds;
    logic        lds;
    logic        rd;
    logic [2:0]  fc;
    logic [15:0] wd;
  } cyc_exp_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic [1:0]  st;
  } rsp_exp_t;

  typedef struct {
    logic [1:0]  size;
    logic        rd;
    logic [23:0] addr;
    logic [31:0] wdata;
    logic [2:0]  fc;
    logic [15:0] rd1;
    logic [15:0] rd2;
    logic        berr;
    int          ncyc;
    logic [22:0] a1;
    logic [22:0] a2;
    logic        uds;
    logic        lds;
    logic [15:0] wd1;
    logic [15:0] wd2;
    logic [31:0] ex_rdata;
    logic [1:0]  ex_st;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int cur_tag = 0;
  cyc_exp_t cyc_q[$];
  rsp_exp_t rsp_q[$];
  vec_t vecs[12];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] actual=%0h expected=%0h", name, cur_tag, act, exp);
    end
  endtask

  function automatic cyc_exp_t cur_cyc();
    return '{bus.cyc_addr, bus.cyc_uds, bus.cyc_lds, bus.cyc_read, bus.cyc_fc, bus.cyc_wdata};
  endfunction

  task automatic drive_req(input logic [1:0] size, input logic rd, input logic [23:0] addr,
                           input logic [31:0] wdata, input logic [2:0] fc);
    bus.req_size  = size;
    bus.req_read  = rd;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_fc    = fc;
    bus.req_valid = 1'b1;
    @(negedge sys_clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    cyc_exp_t ce;
    rsp_exp_t re;
    cur_tag = idx;
    cyc_q.delete();
    rsp_q.delete();
    chk("req_ready_idle", bus.req_ready, 1);
    for (int k = 0; k < v.ncyc; k++)
      cyc_q.push_back('{(k == 0) ? v.a1 : v.a2, v.uds, v.lds, v.rd, v.fc, (k == 0) ? v.wd1 : v.wd2});
    rsp_q.push_back('{v.ex_rdata, v.ex_st});
    drive_req(v.size, v.rd, v.addr, v.wdata, v.fc);
    chk("req_ready_busy", bus.req_ready, 0);
    if (v.ncyc == 0) chk("no_cyc_on_addr_err", bus.cyc_valid, 0);
    for (int k = 0; k < v.ncyc; k++) begin
      chk("cyc_valid_lat", bus.cyc_valid, 1);
      if (!bus.cyc_valid) return;
      ce = cyc_q.pop_front();
      chk("cyc_fields", cur_cyc(), ce);
      @(negedge sys_clk);
      chk("cyc_hold", {bus.cyc_valid, cur_cyc()}, {1'b1, ce});
      bus.cyc_ready = 1'b1;
      @(negedge sys_clk);
      bus.cyc_ready = 1'b0;
      chk("cyc_valid_drop", bus.cyc_valid, 0);
      @(negedge sys_clk);
      bus.cyc_rdata = (k == 0) ? v.rd1 : v.rd2;
      bus.cyc_berr  = (k == 0) && v.berr;
      bus.cyc_done  = 1'b1;
      @(negedge sys_clk);
      bus.cyc_done  = 1'b0;
      bus.cyc_berr  = 1'b0;
      bus.cyc_rdata = 16'hFFFF;
      if (v.berr) break;
    end
    chk("rsp_done_lat", bus.rsp_done, 1);
    if (rsp_q.size() == 0) begin
      chk("rsp_q_underflow", 1, 0);
      return;
    end
    re = rsp_q.pop_front();
    chk("rsp_fields", {bus.rsp_rdata, bus.rsp_status, bus.cyc_abort}, {re, 1'b0});
    @(negedge sys_clk);
    chk("rsp_after", {bus.rsp_done, bus.req_ready, bus.cyc_valid, bus.rsp_rdata, bus.rsp_status},
        {1'b0, 1'b1, 1'b0, re});
    chk("cyc_q_empty", cyc_q.size(), 0);
  endtask

  // Word read to 0x000040 left hanging for 8 wait cycles, optionally terminated on the last one.
  task automatic timeout_seq(input int tag, input logic with_done);
    logic early;
    cur_tag = tag;
    drive_req(2'd1, 1'b1, 24'h000040, 32'h0, 3'd5);
    chk("to_cyc_valid", {bus.cyc_valid, bus.cyc_addr}, {1'b1, 23'h20});
    bus.cyc_ready = 1'b1;
    @(negedge sys_clk);
    bus.cyc_ready = 1'b0;
    early = 1'b0;
    for (int j = 1; j <= 8; j++) begin
      if (bus.cyc_abort || bus.rsp_done) early = 1'b1;
      if (j < 8) @(negedge sys_clk);
    end
    chk("to_no_early_end", early, 0);
    if (with_done) begin
      bus.cyc_rdata = 16'h4321;
      bus.cyc_done  = 1'b1;
    end
    @(negedge sys_clk);
    bus.cyc_done = 1'b0;
    if (with_done)
      chk("to_done_wins", {bus.cyc_abort, bus.rsp_done, bus.rsp_status, bus.rsp_rdata},
          {1'b0, 1'b1, 2'd0, 32'h00004321});
    else
      chk("to_abort", {bus.cyc_abort, bus.rsp_done, bus.rsp_status}, {1'b1, 1'b1, 2'd3});
    @(negedge sys_clk);
    chk("to_after", {bus.cyc_abort, bus.rsp_done, bus.req_ready}, {1'b0, 1'b0, 1'b1});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.req_size  = '0;
    bus.req_read  = 1'b0;
    bus.req_fc    = '0;
    bus.req_wdata = '0;
    bus.cyc_ready = 1'b0;
    bus.cyc_done  = 1'b0;
    bus.cyc_berr  = 1'b0;
    bus.cyc_rdata = '0;

    //            size  rd  addr          wdata         fc    rd1      rd2      berr n  a1          a2        uds lds wd1      wd2      rdata          st
    vecs[0]  = '{2'd1, 1, 24'h00DFF01C, 32'h00000000, 3'd5, 16'h1234, 16'h0000, 0, 1, 23'h6FF80E, 23'h0,    1, 1, 16'h0000, 16'h0000, 32'h00001234, 2'd0};
    vecs[1]  = '{2'd2, 0, 24'hFFFFFE,   32'hAABBCCDD, 3'd1, 16'h0000, 16'h0000, 0, 2, 23'h7FFFFF, 23'h0,    1, 1, 16'hAABB, 16'hCCDD, 32'h00000000, 2'd0};
    vecs[2]  = '{2'd0, 1, 24'h000001,   32'h00000000, 3'd5, 16'h5A7E, 16'h0000, 0, 1, 23'h000000, 23'h0,    0, 1, 16'h0000, 16'h0000, 32'h0000007E, 2'd0};
    vecs[3]  = '{2'd0, 0, 24'h000010,   32'h0000003C, 3'd1, 16'h0000, 16'h0000, 0, 1, 23'h000008, 23'h0,    1, 0, 16'h3C3C, 16'h0000, 32'h00000000, 2'd0};
    vecs[4]  = '{2'd2, 1, 24'h000003,   32'h00000000, 3'd5, 16'h0000, 16'h0000, 0, 0, 23'h0,      23'h0,    0, 0, 16'h0000, 16'h0000, 32'h00000000, 2'd2};
    vecs[5]  = '{2'd2, 1, 24'h000100,   32'h00000000, 3'd5, 16'h7777, 16'h0000, 1, 1, 23'h000080, 23'h0,    1, 1, 16'h0000, 16'h0000, 32'h00000000, 2'd1};
    vecs[6]  = '{2'd2, 1, 24'h001000,   32'h00000000, 3'd6, 16'hDEAD, 16'hBEEF, 0, 2, 23'h000800, 23'h801,  1, 1, 16'h0000, 16'h0000, 32'hDEADBEEF, 2'd0};
    vecs[7]  = '{2'd0, 1, 24'h000002,   32'h00000000, 3'd5, 16'h5A7E, 16'h0000, 0, 1, 23'h000001, 23'h0,    1, 0, 16'h0000, 16'h0000, 32'h0000005A, 2'd0};
    vecs[8]  = '{2'd1, 0, 24'h000005,   32'h00001111, 3'd1, 16'h0000, 16'h0000, 0, 0, 23'h0,      23'h0,    0, 0, 16'h0000, 16'h0000, 32'h00000000, 2'd2};
    vecs[9]  = '{2'd3, 1, 24'h000004,   32'h00000000, 3'd5, 16'h0000, 16'h0000, 0, 0, 23'h0,      23'h0,    0, 0, 16'h0000, 16'h0000, 32'h00000000, 2'd2};
    vecs[10] = '{2'd1, 0, 24'h123456,   32'h1234BEEF, 3'd2, 16'h0000, 16'h0000, 0, 1, 23'h091A2B, 23'h0,    1, 1, 16'hBEEF, 16'h0000, 32'h00000000, 2'd0};
    vecs[11] = '{2'd0, 0, 24'h000007,   32'hFFFFFFA5, 3'd6, 16'h0000, 16'h0000, 0, 1, 23'h000003, 23'h0,    0, 1, 16'hA5A5, 16'h0000, 32'h00000000, 2'd0};

    // Reset state, both during and after reset.
    repeat (2) @(negedge sys_clk);
    cur_tag = 100;
    chk("reset_state", {bus.req_ready, bus.cyc_valid, bus.cyc_abort, bus.rsp_done, bus.rsp_status,
                        bus.rsp_rdata, cur_cyc()}, {4'b1000, 2'd0, 32'd0, 45'd0});
    reset = 1'b0;
    @(negedge sys_clk);
    cur_tag = 101;
    chk("post_reset_state", {bus.req_ready, bus.cyc_valid, bus.cyc_abort, bus.rsp_done, bus.rsp_status,
                             bus.rsp_rdata, cur_cyc()}, {4'b1000, 2'd0, 32'd0, 45'd0});

    for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

    timeout_seq(200, 1'b0);
    timeout_seq(201, 1'b1);

    // Stray termination while idle must be ignored.
    cur_tag = 300;
    bus.cyc_done = 1'b1;
    @(negedge sys_clk);
    bus.cyc_done = 1'b0;
    chk("stray_done_ignored", {bus.rsp_done, bus.req_ready, bus.cyc_valid}, {1'b0, 1'b1, 1'b0});

    // Reset while the second half of a long read is outstanding.
    cur_tag = 400;
    drive_req(2'd2, 1'b1, 24'h000200, 32'h0, 3'd5);
    bus.cyc_ready = 1'b1;
    @(negedge sys_clk);
    bus.cyc_ready = 1'b0;
    bus.cyc_rdata = 16'h1111;
    bus.cyc_done  = 1'b1;
    @(negedge sys_clk);
    bus.cyc_done  = 1'b0;
    chk("rst_cyc2_issued", {bus.cyc_valid, bus.cyc_addr, bus.rsp_rdata}, {1'b1, 23'h101, 32'h11110000});
    bus.cyc_ready = 1'b1;
    @(negedge sys_clk);
    bus.cyc_ready = 1'b0;
    reset = 1'b1;
    #1;
    chk("rst_in_wait2", {bus.cyc_valid, bus.rsp_done, bus.rsp_rdata, bus.req_ready}, {1'b0, 1'b0, 32'd0, 1'b1});
    @(negedge sys_clk);
    reset = 1'b0;
    @(negedge sys_clk);
    chk("rst_release", {bus.req_ready, bus.rsp_done, bus.cyc_valid, bus.cyc_abort}, {1'b1, 1'b0, 1'b0, 1'b0});

    run_vec(500, vecs[0]);
    run_vec(501, vecs[6]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
